sap_1_controller_sequencer: RTL
===============================

Name: sap_1_controller_sequencer

Overview:
Controller-sequencer for the SAP-1 datapath: the MAR/ROM pair, program counter, IR, accumulator, B register, adder-subtracter and output register.
- A 6-state ring counter (T1..T6) runs the fetch cycle (T1-T3) and the execute cycle (T4-T6).
- In each T-state it decodes the IR opcode into the 12-bit control word, including the LMbar and CEbar strobes consumed by the MAR/ROM top.
- Handles halt.

Parameters:
OP_LDA, 4'h0, LDA opcode
OP_ADD, 4'h1, ADD opcode
OP_SUB, 4'h2, SUB opcode
OP_OUT, 4'hE, OUT opcode
OP_HLT, 4'hF, HLT opcode

Ports:
Clk  input  1  system clock; the ring counter advances on the FALLING edge so the control word is stable at datapath rising edges
CLRbar  input  1  asynchronous active-low reset
opcode  input  4  IR upper nibble; sampled combinationally in T4-T6 and at the T3->T4 edge
CON  output  12  control word {Cp,Ep,LMbar,CEbar,LIbar,EIbar,LAbar,EA,Su,EU,LBbar,LObar} (bit 11..0)
T  output  6  one-hot ring state, T[0]=T1 .. T[5]=T6
HLTbar  output  1  0 = halted (sticky until reset)

Behaviour:
- Clocking and reset:
  - One clock (Clk); reset is CLRbar, asynchronous, active-low.
  - While CLRbar=0: T=6'b000001, halted=0, HLTbar=1, CON forced to NOP 12'h3E3 (all strobes inactive).
  - On CLRbar release, CON immediately decodes T1 (12'h5E3). The first falling edge moves to T2.
- Ring counter:
  - T1->T2->...->T6->T1, one step per falling Clk edge.
  - Exactly one bit of T is set at all times; there are no illegal states. If a non-one-hot value is ever detected, the counter loads T1 on the next edge.
- CON decode is combinational from T, opcode and halted. Idle value NOP = 12'h3E3.
  - T1 (address): 12'h5E3 (Ep=1, LMbar=0).
  - T2 (increment): 12'hBE3 (Cp=1).
  - T3 (memory): 12'h263 (CEbar=0, LIbar=0).
  - LDA: T4 12'h1A3 (LMbar=0, EIbar=0); T5 12'h2C3 (CEbar=0, LAbar=0); T6 NOP.
  - ADD: T4 12'h1A3; T5 12'h2E1 (CEbar=0, LBbar=0); T6 12'h3C7 (EU=1, LAbar=0).
  - SUB: same as ADD except T6 12'h3CF (Su=1, EU=1, LAbar=0).
  - OUT: T4 12'h3F2 (EA=1, LObar=0); T5, T6 NOP.
  - Undefined opcodes (3..D): NOP in T4-T6; the sequence continues normally.
- Halt:
  - At the falling edge leaving T3, if opcode==OP_HLT: T becomes T4 and halted is set.
  - While halted: T holds at T4, CON=NOP, HLTbar=0, and all clock edges are ignored.
  - Only CLRbar clears the halt.
- Reset mid-instruction: asynchronous return to T1 and NOP from any state, including halted. No partial strobes persist after CLRbar falls.
- Opcode changes outside T4-T6 have no effect on CON.

Test Plan:
- Reset: hold CLRbar=0 while toggling Clk and opcode -> T=000001, CON=3E3, HLTbar=1 throughout.
- Fetch plus LDA: opcode=0, release CLRbar, 6 falling edges -> CON sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then returns to 5E3 with T=000001.
- ADD then SUB: opcode=1 for one cycle, then opcode=2 -> T4-T6 give 1A3, 2E1, 3C7, then 1A3, 2E1, 3CF. Fetch words are unchanged between the two instructions.
- OUT and undefined opcode: opcode=E -> T4-T6 = 3F2, 3E3, 3E3. opcode=7 -> T4-T6 all 3E3, and the ring continues to wrap.
- Halt: opcode=F at the T3->T4 edge -> T=001000, HLTbar=0, CON=3E3. Then 20 more edges with opcode changed to 0 -> no change. Pulse CLRbar low -> T1, HLTbar=1.
- Async reset mid-T5 of ADD (CEbar and LBbar active): drop CLRbar between clock edges -> CON=3E3 and T=000001 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sap_1_controller_sequencer_if.sv
// sap_1_controller_sequencer_if: opcode in, control word / ring state / halt flag out
interface sap_1_controller_sequencer_if;
   logic [3:0]  opcode;
   logic [11:0] CON;
   logic [5:0]  T;
   logic        HLTbar;
   modport master (input opcode, output CON, output T, output HLTbar);
   modport slave  (output opcode, input CON, input T, input HLTbar);
endinterface

// File: rtl/sap_1_controller_sequencer.sv
// sap_1_controller_sequencer: SAP-1 six-state ring counter and control word decoder
module sap_1_controller_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input logic Clk,
   input logic CLRbar,
   sap_1_controller_sequencer_if.master bus
);
   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } state_t;
   localparam logic [11:0] NOP = 12'h3E3;
   state_t      state, state_nxt;
   logic        halted, halted_nxt;
   logic [11:0] con;
   logic        is_add, is_sub, is_lda, mem_ref;
   assign is_lda  = bus.opcode == OP_LDA;
   assign is_add  = bus.opcode == OP_ADD;
   assign is_sub  = bus.opcode == OP_SUB;
   assign mem_ref = is_lda | is_add | is_sub;
   // ring advances on the falling edge so CON is settled for the datapath's rising edge
   always_ff @(negedge Clk or negedge CLRbar) begin
      if (!CLRbar) begin
         state  <= T1;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         halted <= halted_nxt;
      end
   end
   // next ring state; HLT is caught on the T3->T4 edge and freezes the ring at T4
   always_comb begin
      state_nxt  = T1;
      halted_nxt = halted;
      if (halted) state_nxt = T4;
      else begin
         case (state)
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            T3: begin
               state_nxt  = T4;
               halted_nxt = bus.opcode == OP_HLT;
            end
            T4: state_nxt = T5;
            T5: state_nxt = T6;
            default: state_nxt = T1;
         endcase
      end
   end
   // control word decode; reset and halt force every strobe inactive
   always_comb begin
      con = NOP;
      case (state)
         T1: con = 12'h5E3;
         T2: con = 12'hBE3;
         T3: con = 12'h263;
         T4: con = mem_ref ? 12'h1A3 : (bus.opcode == OP_OUT) ? 12'h3F2 : NOP;
         T5: con = is_lda ? 12'h2C3 : (is_add | is_sub) ? 12'h2E1 : NOP;
         T6: con = is_add ? 12'h3C7 : is_sub ? 12'h3CF : NOP;
         default: con = NOP;
      endcase
      if (!CLRbar || halted) con = NOP;
   end
   assign bus.CON    = con;
   assign bus.T      = state;
   assign bus.HLTbar = ~halted;
endmodule
